// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60Hz timing constants and shared types for the
// VGA raster timing generator.
//   H_* / V_*     visible, front porch, sync and back porch widths
//   H_TOTAL/V_TOTAL  full line / frame lengths in pixels / lines
//   CLK_DIV       system clocks per pixel
//   coord_t       10-bit DrawX/DrawY coordinate type
//   in_range()    half-open interval test used by the sync decodes
package vga_pkg;

   localparam int H_VISIBLE = 640;
   localparam int H_FP      = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BP      = 48;
   localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

   localparam int V_VISIBLE = 480;
   localparam int V_FP      = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BP      = 33;
   localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam int CLK_DIV   = 2;

   localparam int COORD_W   = 10;
   localparam int COORD_LIM = 1 << COORD_W;

   typedef logic [COORD_W-1:0] coord_t;

   // lo <= v < hi
   function automatic logic in_range(input coord_t v, input int lo, input int hi);
      return (int'(v) >= lo) && (int'(v) < hi);
   endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// vga_pixel_tick: divides the system clock into pixel periods.
//   Clk         in   system clock
//   Reset       in   synchronous, active-high reset
//   pixel_tick  out  high on the last Clk cycle of each CLK_DIV-cycle period
// pixel_tick is registered so it reads 0 while in reset, even for CLK_DIV=1
// where it is otherwise constantly high.
module vga_pixel_tick
   import vga_pkg::*;
#(
   parameter int CLK_DIV = vga_pkg::CLK_DIV
) (
   input  logic Clk,
   input  logic Reset,
   output logic pixel_tick
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_pixel_tick: CLK_DIV must be >= 1");
   end

   logic [DW-1:0] div;
   logic [DW-1:0] div_nxt;

   always_comb begin
      div_nxt = div + 1'b1;
      if (div == DIV_LAST) div_nxt = '0;
   end

   // tick is decoded from the next divider state so it lines up with div
   always_ff @(posedge Clk) begin
      if (Reset) begin
         div        <= '0;
         pixel_tick <= 1'b0;
      end else begin
         div        <= div_nxt;
         pixel_tick <= (div_nxt == DIV_LAST);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60Hz VGA raster timing from the 50 MHz clock.
//   Clk          in   system clock
//   Reset        in   synchronous, active-high reset
//   pixel_tick   out  last Clk cycle of each pixel period
//   DrawX/DrawY  out  raster position, 0..H_TOTAL-1 / 0..V_TOTAL-1
//   hs, vs       out  active-low syncs
//   blank_n      out  high inside the visible area
//   frame_start  out  one-cycle pulse after the raster wraps to (0,0)
//   frame_count  out  16-bit frame counter, present only when
//                     VGA_FRAME_CNT_EN is defined
// All outputs are registered. Syncs and blank are decoded from the next
// counter values so they change on the same edge as DrawX/DrawY.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
   parameter int H_FP      = vga_pkg::H_FP,
   parameter int H_SYNC    = vga_pkg::H_SYNC,
   parameter int H_BP      = vga_pkg::H_BP,
   parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
   parameter int V_FP      = vga_pkg::V_FP,
   parameter int V_SYNC    = vga_pkg::V_SYNC,
   parameter int V_BP      = vga_pkg::V_BP,
   parameter int CLK_DIV   = vga_pkg::CLK_DIV
) (
   input  logic        Clk,
   input  logic        Reset,
   output logic        pixel_tick,
   output coord_t      DrawX,
   output coord_t      DrawY,
   output logic        hs,
   output logic        vs,
   output logic        blank_n,
   output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [15:0] frame_count
`endif
);

   localparam int H_TOT    = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT    = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_VISIBLE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VISIBLE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   if (H_TOT > COORD_LIM || V_TOT > COORD_LIM || H_TOT < 1 || V_TOT < 1) begin : g_bad_tot
      $error("vga_timing_gen: line/frame totals must fit in 10-bit counters");
   end

   localparam coord_t H_LAST = coord_t'(H_TOT - 1);
   localparam coord_t V_LAST = coord_t'(V_TOT - 1);

   vga_pixel_tick #(
      .CLK_DIV    (CLK_DIV)
   ) u_tick (
      .Clk        (Clk),
      .Reset      (Reset),
      .pixel_tick (pixel_tick)
   );

   coord_t x_nxt;
   coord_t y_nxt;
   logic   line_end;
   logic   frame_end;
   logic   hs_nxt;
   logic   vs_nxt;
   logic   blank_n_nxt;

   always_comb begin
      x_nxt     = DrawX;
      y_nxt     = DrawY;
      line_end  = (DrawX == H_LAST);
      frame_end = line_end && (DrawY == V_LAST);
      if (pixel_tick) begin
         if (line_end) begin
            x_nxt = '0;
            y_nxt = (DrawY == V_LAST) ? '0 : DrawY + 1'b1;
         end else begin
            x_nxt = DrawX + 1'b1;
         end
      end
      hs_nxt      = !in_range(x_nxt, HS_START, HS_END);
      vs_nxt      = !in_range(y_nxt, VS_START, VS_END);
      blank_n_nxt = in_range(x_nxt, 0, H_VISIBLE) && in_range(y_nxt, 0, V_VISIBLE);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         DrawX       <= '0;
         DrawY       <= '0;
         hs          <= 1'b1;
         vs          <= 1'b1;
         blank_n     <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         DrawX       <= x_nxt;
         DrawY       <= y_nxt;
         hs          <= hs_nxt;
         vs          <= vs_nxt;
         blank_n     <= blank_n_nxt;
         // only a real wrap pulses; leaving reset at (0,0) does not
         frame_start <= pixel_tick && frame_end;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_count <= '0;
      end else if (pixel_tick && frame_end) begin
         frame_count <= frame_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: self-checking bench for vga_timing_gen.
// Instance a uses the default 640x480 timing; instance b uses a tiny raster
// so whole frames, vertical sync and mid-frame reset fit in a short run.
// Expected outputs come from a closed-form model of cycles-since-reset,
// queued at each posedge and compared at the following negedge.
module tb_vga_timing_gen;
   import vga_pkg::*;

   typedef struct {
      int hv, hf, hs, hb, vv, vf, vs, vb, d;
   } tim_t;

   typedef struct {
      int   n;
      logic tick;
      int   x;
      int   y;
      logic hs;
      logic vs;
      logic bn;
      logic fs;
      int   fc;
   } exp_t;

   localparam tim_t TA = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
   localparam tim_t TB = '{16, 2, 4, 3, 6, 1, 2, 2, 2};
   localparam int   B_FRAME = 2 * 25 * 11;

   logic   Clk = 1'b0;
   logic   rst_a = 1'b1;
   logic   rst_b = 1'b1;
   logic   tick_a, hs_a, vs_a, bn_a, fs_a;
   logic   tick_b, hs_b, vs_b, bn_b, fs_b;
   coord_t x_a, y_a, x_b, y_b;
   logic [15:0] fc_a, fc_b;

   always #10 Clk = ~Clk;

   vga_timing_gen u_a (
      .Clk         (Clk),
      .Reset       (rst_a),
      .pixel_tick  (tick_a),
      .DrawX       (x_a),
      .DrawY       (y_a),
      .hs          (hs_a),
      .vs          (vs_a),
      .blank_n     (bn_a),
      .frame_start (fs_a)
`ifdef VGA_FRAME_CNT_EN
      ,
      .frame_count (fc_a)
`endif
   );

   vga_timing_gen #(
      .H_VISIBLE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
      .V_VISIBLE (6),  .V_FP (1), .V_SYNC (2), .V_BP (2),
      .CLK_DIV   (2)
   ) u_b (
      .Clk         (Clk),
      .Reset       (rst_b),
      .pixel_tick  (tick_b),
      .DrawX       (x_b),
      .DrawY       (y_b),
      .hs          (hs_b),
      .vs          (vs_b),
      .blank_n     (bn_b),
      .frame_start (fs_b)
`ifdef VGA_FRAME_CNT_EN
      ,
      .frame_count (fc_b)
`endif
   );

`ifndef VGA_FRAME_CNT_EN
   assign fc_a = '0;
   assign fc_b = '0;
`endif

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input int n, input tim_t t);
      exp_t e;
      int ht, vt, px;
      ht     = t.hv + t.hf + t.hs + t.hb;
      vt     = t.vv + t.vf + t.vs + t.vb;
      px     = n / t.d;
      e.n    = n;
      e.tick = ((n % t.d) == t.d - 1);
      e.x    = px % ht;
      e.y    = (px / ht) % vt;
      e.hs   = !(e.x >= t.hv + t.hf && e.x < t.hv + t.hf + t.hs);
      e.vs   = !(e.y >= t.vv + t.vf && e.y < t.vv + t.vf + t.vs);
      e.bn   = (e.x < t.hv) && (e.y < t.vv);
      e.fs   = (n > 0) && ((n % (t.d * ht * vt)) == 0);
      e.fc   = (n / (t.d * ht * vt)) % 65536;
      return e;
   endfunction

   task automatic cmp(input string p, input exp_t e, input logic tick, input int x,
                      input int y, input logic hs, input logic vs, input logic bn,
                      input logic fs, input int fc);
      chk({p, ".tick"}, int'(tick), int'(e.tick));
      chk({p, ".x"},    x,          e.x);
      chk({p, ".y"},    y,          e.y);
      chk({p, ".hs"},   int'(hs),   int'(e.hs));
      chk({p, ".vs"},   int'(vs),   int'(e.vs));
      chk({p, ".bn"},   int'(bn),   int'(e.bn));
      chk({p, ".fs"},   int'(fs),   int'(e.fs));
`ifdef VGA_FRAME_CNT_EN
      chk({p, ".fc"},   fc,         e.fc);
`else
      if (fc != 0) chk({p, ".fc_tie"}, fc, 0);
`endif
   endtask

   exp_t qa[$];
   exp_t qb[$];
   int   n_a = 0;
   int   n_b = 0;

   // model: cycles since the last reset edge -> expected post-edge outputs
   initial forever begin
      @(posedge Clk);
      if (rst_a) n_a = 0; else n_a++;
      if (rst_b) n_b = 0; else n_b++;
      qa.push_back(model(n_a, TA));
      qb.push_back(model(n_b, TB));
   end

   bit ph1 = 1'b1;
   int hs_lo_a = 0;
   int bn_lo_a = 0;
   int vs_lo_b = 0;
   int pulses_b = 0;

   initial forever begin
      exp_t ea, eb;
      @(negedge Clk);
      if (qa.size() > 0) begin
         ea = qa.pop_front();
         cmp("a", ea, tick_a, int'(x_a), int'(y_a), hs_a, vs_a, bn_a, fs_a, int'(fc_a));
         if (ph1 && ea.n < 1600) begin
            if (!hs_a) hs_lo_a++;
            if (!bn_a) bn_lo_a++;
         end
      end
      if (qb.size() > 0) begin
         eb = qb.pop_front();
         cmp("b", eb, tick_b, int'(x_b), int'(y_b), hs_b, vs_b, bn_b, fs_b, int'(fc_b));
         if (ph1 && eb.n < B_FRAME && !vs_b) vs_lo_b++;
         if (ph1 && fs_b && eb.n <= 8 * B_FRAME) begin
            pulses_b++;
            chk("b.fs_period", eb.n % B_FRAME, 0);
         end
      end
   end

   initial begin
      bit hit;
      repeat (3) @(negedge Clk);
      rst_a = 1'b0;
      rst_b = 1'b0;
      repeat (4800) @(negedge Clk);
      ph1 = 1'b0;

      // mid-line reset on the full-size raster
      hit = 1'b0;
      for (int i = 0; i < 2000 && !hit; i++) begin
         @(negedge Clk);
         hit = (x_a == 10'd300);
      end
      chk("a.wait_x300", int'(hit), 1);
      rst_a = 1'b1;
      @(negedge Clk);
      rst_a = 1'b0;

      // mid-frame reset on the small raster
      hit = 1'b0;
      for (int i = 0; i < 1000 && !hit; i++) begin
         @(negedge Clk);
         hit = (x_b == 10'd10) && (y_b == 10'd5);
      end
      chk("b.wait_mid", int'(hit), 1);
      rst_b = 1'b1;
      @(negedge Clk);
      rst_b = 1'b0;

      repeat (700) @(negedge Clk);

      chk("a.hs_lo_line0", hs_lo_a, 192);
      chk("a.blank_line0", bn_lo_a, 320);
      chk("b.vs_lo_frame", vs_lo_b, 2 * 25 * 2);
      chk("b.pulse_cnt",   pulses_b, 8);

      $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
      $finish;
   end

endmodule
